// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and burst FSM states.
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD     = 3'b000;
    localparam logic [2:0] MODE_LOAD     = 3'b001;
    localparam logic [2:0] MODE_SHL      = 3'b010;
    localparam logic [2:0] MODE_SHR      = 3'b011;
    localparam logic [2:0] MODE_ASR      = 3'b100;
    localparam logic [2:0] MODE_ROL      = 3'b101;
    localparam logic [2:0] MODE_ROR      = 3'b110;
    localparam logic [2:0] MODE_INC_LFSR = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } shreg_state_t;

endpackage

// File: rtl/shreg_step.sv
// Combinational step function f(q) of the universal shift register.
// Mode 111 is increment by default, or a Fibonacci LFSR step when SHREG_LFSR_EN is defined.
module shreg_step
    import shreg_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_step
);

    logic [WIDTH-1:0] q_alt;

`ifdef SHREG_LFSR_EN
    // An all-zero register has zero parity feedback, so it stays at zero.
    assign q_alt = {q[WIDTH-2:0], ^(q & TAPS)};
`else
    assign q_alt = q + {{(WIDTH-1){1'b0}}, 1'b1};
`endif

    always_comb begin
        q_step = q;
        case (mode)
            MODE_HOLD:     q_step = q;
            MODE_LOAD:     q_step = pin;
            MODE_SHL:      q_step = {q[WIDTH-2:0], sin_l};
            MODE_SHR:      q_step = {sin_r, q[WIDTH-1:1]};
            MODE_ASR:      q_step = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_ROL:      q_step = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:      q_step = {q[0], q[WIDTH-1:1]};
            MODE_INC_LFSR: q_step = q_alt;
            default:       q_step = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with single-step modes and a counted burst engine.
// Build with SHREG_LFSR_EN to turn mode 111 into an LFSR step using TAPS.
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               CNT_W = 4,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    shreg_state_t     state_reg, state_next;
    logic [CNT_W-1:0] rem_reg, rem_next;
    logic [2:0]       mode_reg, mode_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             done_reg, done_next;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;

    // During a burst the latched mode drives the step function; otherwise the live mode.
    assign step_mode = (state_reg == ST_RUN) ? mode_reg : mode;

    shreg_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .q      (q_reg),
        .mode   (step_mode),
        .pin    (pin),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_step (step_q)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= ST_IDLE;
            rem_reg   <= '0;
            mode_reg  <= MODE_HOLD;
            q_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            mode_reg  <= mode_next;
            q_reg     <= q_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        mode_next  = mode_reg;
        q_next     = q_reg;
        done_next  = 1'b0;
        if (pre) begin
            q_next     = '1;
            state_next = ST_IDLE;
            rem_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (cnt == '0) begin
                            done_next = 1'b1;
                        end else begin
                            mode_next  = mode;
                            rem_next   = cnt;
                            state_next = ST_RUN;
                        end
                    end else if (en) begin
                        q_next = step_q;
                    end
                end
                ST_RUN: begin
                    q_next   = step_q;
                    rem_next = rem_reg - CNT_W'(1);
                    if (rem_reg == CNT_W'(1)) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign q      = q_reg;
    assign busy   = (state_reg == ST_RUN);
    assign done   = done_reg;
    assign sout_l = q_reg[WIDTH-1];
    assign sout_r = q_reg[0];

endmodule
